// File: rtl/verificador_sumador4_pkg.sv
// Shared constants and FSM encoding for the 4-bit adder sweep checker.
//   ANCHO          operand width of the adder under test
//   COMBINACIONES  values per operand (2**ANCHO)
//   TOTAL_PARES    operand pairs in one full sweep
//   ANCHO_ETIQUETA width of the {valid, X, Y} tag carried by the delay line
package verificador_sumador4_pkg;

  localparam int unsigned ANCHO          = 4;
  localparam int unsigned COMBINACIONES  = 16;
  localparam int unsigned TOTAL_PARES    = 256;
  localparam int unsigned ANCHO_ETIQUETA = 2 * ANCHO + 1;

  typedef enum logic [1:0] {
    REPOSO = 2'd0,
    GENERA = 2'd1,
    DRENA  = 2'd2,
    FIN    = 2'd3
  } estado_t;

endpackage

// File: rtl/verificador_sumador4_linea_retardo.sv
// Fixed-depth register delay line with asynchronous clear.
//   clk      rising-edge clock
//   rst      asynchronous active-high clear of every stage
//   entrada  word captured into the first stage each cycle
//   salida   word leaving the last stage (PROFUNDIDAD cycles later)
module linea_retardo #(
  parameter int unsigned PROFUNDIDAD = 1,
  parameter int unsigned ANCHO_DATOS = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ANCHO_DATOS-1:0] entrada,
  output logic [ANCHO_DATOS-1:0] salida
);

  logic [ANCHO_DATOS-1:0] etapas [PROFUNDIDAD];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < PROFUNDIDAD; i++) begin
        etapas[i] <= '0;
      end
    end else begin
      etapas[0] <= entrada;
      for (int unsigned i = 1; i < PROFUNDIDAD; i++) begin
        etapas[i] <= etapas[i-1];
      end
    end
  end

  assign salida = etapas[PROFUNDIDAD-1];

endmodule

// File: rtl/verificador_sumador4.sv
// Exhaustive checker for a 4-bit adder with LATENCIA cycles of pipeline delay.
// Drives all 256 operand pairs, compares each returned {carry, sum} against
// X+Y and reports a mismatch count plus the first failing pair.
//   Reloj        clock, rising edge
//   Reset        asynchronous active-high reset
//   Inicio       start request (accepted only when idle or finished)
//   SalidaDUT    sum from the adder under test
//   CarriDUT     carry-out from the adder under test
//   XDut, YDut   registered operands to the adder
//   Ocupado      sweep or drain in progress
//   Hecho        sweep completed, held until next start
//   Pasa         Hecho with zero mismatches
//   Errores      mismatch count of the current or last sweep
//   FalloValido  at least one mismatch recorded
//   PrimerFallo  {X,Y} of the first mismatching pair
module verificador_sumador4
  import verificador_sumador4_pkg::*;
#(
  parameter int unsigned LATENCIA = 0
) (
  input  logic             Reloj,
  input  logic             Reset,
  input  logic             Inicio,
  input  logic [ANCHO-1:0] SalidaDUT,
  input  logic             CarriDUT,
  output logic [ANCHO-1:0] XDut,
  output logic [ANCHO-1:0] YDut,
  output logic             Ocupado,
  output logic             Hecho,
  output logic             Pasa,
  output logic [8:0]       Errores,
  output logic             FalloValido,
  output logic [7:0]       PrimerFallo
);

  localparam logic [1:0]         FIN_DRENA = 2'(LATENCIA);
  localparam logic [2*ANCHO-1:0] UNO_PAR   = (2*ANCHO)'(1);

  estado_t estado, estado_sig;

  logic [ANCHO-1:0] x_sig, y_sig;
  logic             valida_sig;
  logic             arranque;
  logic [1:0]       contador_drena;

  logic [ANCHO_ETIQUETA-1:0] etiqueta_in, etiqueta_out;
  logic                      comp_valida;
  logic [ANCHO-1:0]          comp_x, comp_y;
  logic [ANCHO:0]            esperado, obtenido;
  logic                      discrepancia;

  // Next-pair and next-state decode. The delay line is fed with the values
  // about to be loaded into XDut/YDut, so its first stage lines up with the
  // operand registers and a depth of LATENCIA+1 lands each tag on the edge
  // where the adder's answer for that pair is sampled.
  always_comb begin
    estado_sig = estado;
    x_sig      = XDut;
    y_sig      = YDut;
    arranque   = 1'b0;
    case (estado)
      REPOSO, FIN: begin
        if (Inicio) begin
          arranque   = 1'b1;
          estado_sig = GENERA;
          x_sig      = '0;
          y_sig      = '0;
        end
      end
      GENERA: begin
        if (XDut == '1 && YDut == '1) begin
          estado_sig = DRENA;
        end else begin
          // Y is the low half, so its wrap carries into X.
          {x_sig, y_sig} = {XDut, YDut} + UNO_PAR;
        end
      end
      DRENA: begin
        if (contador_drena == FIN_DRENA) begin
          estado_sig = FIN;
        end
      end
      default: estado_sig = REPOSO;
    endcase
    valida_sig = (estado_sig == GENERA);
  end

  assign etiqueta_in = {valida_sig, x_sig, y_sig};

  linea_retardo #(
    .PROFUNDIDAD(LATENCIA + 1),
    .ANCHO_DATOS(ANCHO_ETIQUETA)
  ) u_linea (
    .clk    (Reloj),
    .rst    (Reset),
    .entrada(etiqueta_in),
    .salida (etiqueta_out)
  );

  assign {comp_valida, comp_x, comp_y} = etiqueta_out;
  assign esperado     = {1'b0, comp_x} + {1'b0, comp_y};
  assign obtenido     = {CarriDUT, SalidaDUT};
  assign discrepancia = comp_valida && (esperado != obtenido);

  always_ff @(posedge Reloj or posedge Reset) begin
    if (Reset) begin
      estado         <= REPOSO;
      XDut           <= '0;
      YDut           <= '0;
      contador_drena <= '0;
      Ocupado        <= 1'b0;
      Hecho          <= 1'b0;
      Errores        <= '0;
      FalloValido    <= 1'b0;
      PrimerFallo    <= '0;
    end else begin
      estado         <= estado_sig;
      XDut           <= x_sig;
      YDut           <= y_sig;
      contador_drena <= (estado == DRENA) ? contador_drena + 2'd1 : '0;
      Ocupado        <= (estado_sig == GENERA) || (estado_sig == DRENA);
      Hecho          <= (estado_sig == FIN);
      if (arranque) begin
        Errores     <= '0;
        FalloValido <= 1'b0;
        PrimerFallo <= '0;
      end else if (discrepancia) begin
        Errores <= Errores + 9'd1;
        if (!FalloValido) begin
          FalloValido <= 1'b1;
          PrimerFallo <= {comp_x, comp_y};
        end
      end
    end
  end

  assign Pasa = Hecho && (Errores == '0);

endmodule

// File: tb/tb_verificador_sumador4.sv
module tb_verificador_sumador4;

  typedef struct {
    int unsigned hecho_ciclo;
    int unsigned errores;
    logic        fallo;
    logic [7:0]  primero;
  } esperado_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned ciclo = 0;
  always @(posedge clk) ciclo++;

  logic rst0, rst2, ini0, ini2;
  logic [3:0] x0, y0, s0, x2, y2, s2;
  logic c0, c2;
  logic ocup0, hecho0, pasa0, fv0, ocup2, hecho2, pasa2, fv2;
  logic [8:0] err0, err2;
  logic [7:0] pf0, pf2;

  // Fault configuration of each adder under test:
  // 0 good, 1 sum bit 0 stuck at 0, 2 carry stuck at 0, 3 flip mask on one pair
  int unsigned modo0 = 0, modo2 = 0;
  logic [7:0] blanco0 = '0, blanco2 = '0;
  logic [4:0] mascara0 = 5'd1, mascara2 = 5'd1;

  int unsigned evaluadas = 0;
  int unsigned fallos = 0;

  esperado_t q0[$];
  esperado_t q2[$];

  function automatic logic [4:0] sumador(input logic [3:0] x, input logic [3:0] y,
                                         input int unsigned modo, input logic [7:0] blanco,
                                         input logic [4:0] mascara);
    logic [4:0] r;
    r = 5'(x) + 5'(y);
    case (modo)
      1: r[0] = 1'b0;
      2: r[4] = 1'b0;
      3: if ({x, y} == blanco) r = r ^ mascara;
      default: ;
    endcase
    return r;
  endfunction

  // Reference: walk all 256 pairs with plain integer arithmetic.
  function automatic esperado_t modelo(input int unsigned inicio, input int unsigned lat,
                                       input int unsigned modo, input logic [7:0] blanco,
                                       input logic [4:0] mascara);
    esperado_t e;
    e.hecho_ciclo = inicio + 257 + lat;
    e.errores = 0;
    e.fallo = 1'b0;
    e.primero = '0;
    for (int k = 0; k < 256; k++) begin
      int unsigned xv, yv, d;
      xv = k / 16;
      yv = k % 16;
      d = sumador(4'(xv), 4'(yv), modo, blanco, mascara);
      if (d != xv + yv) begin
        if (!e.fallo) begin
          e.fallo = 1'b1;
          e.primero = 8'(k);
        end
        e.errores++;
      end
    end
    return e;
  endfunction

  function automatic void comprobar(input string nombre, input longint actual, input longint requerido);
    evaluadas++;
    if (actual != requerido) begin
      fallos++;
      $display("FAIL %s: obtenido %0d, requerido %0d (t=%0t)", nombre, actual, requerido, $time);
    end
  endfunction

  assign {c0, s0} = sumador(x0, y0, modo0, blanco0, mascara0);

  logic [4:0] etapa1, etapa2;
  always @(posedge clk) begin
    etapa1 <= sumador(x2, y2, modo2, blanco2, mascara2);
    etapa2 <= etapa1;
  end
  assign {c2, s2} = etapa2;

  verificador_sumador4 #(.LATENCIA(0)) dut0 (
    .Reloj(clk), .Reset(rst0), .Inicio(ini0), .SalidaDUT(s0), .CarriDUT(c0),
    .XDut(x0), .YDut(y0), .Ocupado(ocup0), .Hecho(hecho0), .Pasa(pasa0),
    .Errores(err0), .FalloValido(fv0), .PrimerFallo(pf0)
  );

  verificador_sumador4 #(.LATENCIA(2)) dut2 (
    .Reloj(clk), .Reset(rst2), .Inicio(ini2), .SalidaDUT(s2), .CarriDUT(c2),
    .XDut(x2), .YDut(y2), .Ocupado(ocup2), .Hecho(hecho2), .Pasa(pasa2),
    .Errores(err2), .FalloValido(fv2), .PrimerFallo(pf2)
  );

  function automatic void revisar(input string t, input esperado_t e, input logic [8:0] err,
                                  input logic pasa, input logic fv, input logic [7:0] pf,
                                  input logic ocup, input logic [3:0] x, input logic [3:0] y);
    comprobar({t, " ciclo_hecho"}, ciclo, e.hecho_ciclo);
    comprobar({t, " errores"}, err, e.errores);
    comprobar({t, " pasa"}, pasa, (e.errores == 0) ? 1 : 0);
    comprobar({t, " fallo_valido"}, fv, e.fallo);
    comprobar({t, " primer_fallo"}, pf, e.primero);
    comprobar({t, " ocupado"}, ocup, 0);
    comprobar({t, " xy_final"}, {x, y}, 8'hFF);
  endfunction

  function automatic void revisar_cero(input string t, input logic ocup, input logic hecho,
                                       input logic pasa, input logic [8:0] err, input logic fv,
                                       input logic [7:0] pf, input logic [3:0] x, input logic [3:0] y);
    comprobar({t, " ocupado"}, ocup, 0);
    comprobar({t, " hecho"}, hecho, 0);
    comprobar({t, " pasa"}, pasa, 0);
    comprobar({t, " errores"}, err, 0);
    comprobar({t, " fallo_valido"}, fv, 0);
    comprobar({t, " primer_fallo"}, pf, 0);
    comprobar({t, " xy"}, {x, y}, 0);
  endfunction

  // Monitors: pop an expectation whenever a checker presents a finished sweep.
  logic hecho0_prev = 1'b0, hecho2_prev = 1'b0;
  always @(negedge clk) begin
    if (hecho0 && !hecho0_prev) begin
      if (q0.size() == 0) comprobar("dut0 hecho_inesperado", ciclo, 0);
      else revisar("dut0", q0.pop_front(), err0, pasa0, fv0, pf0, ocup0, x0, y0);
    end
    hecho0_prev = hecho0;
  end
  always @(negedge clk) begin
    if (hecho2 && !hecho2_prev) begin
      if (q2.size() == 0) comprobar("dut2 hecho_inesperado", ciclo, 0);
      else revisar("dut2", q2.pop_front(), err2, pasa2, fv2, pf2, ocup2, x2, y2);
    end
    hecho2_prev = hecho2;
  end

  task automatic pulso(input logic [1:0] sel);
    @(negedge clk);
    ini0 = sel[0];
    ini2 = sel[1];
    @(negedge clk);
    ini0 = 1'b0;
    ini2 = 1'b0;
    if (sel[0]) q0.push_back(modelo(ciclo, 0, modo0, blanco0, mascara0));
    if (sel[1]) q2.push_back(modelo(ciclo, 2, modo2, blanco2, mascara2));
  endtask

  task automatic esperar_vacio();
    for (int i = 0; i < 1200; i++) begin
      if (q0.size() == 0 && q2.size() == 0) break;
      @(negedge clk);
    end
    comprobar("espera dut0 pendientes", q0.size(), 0);
    comprobar("espera dut2 pendientes", q2.size(), 0);
    q0.delete();
    q2.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulacion sin terminar, obtenido timeout, requerido fin");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned e;
    rst0 = 1'b1;
    rst2 = 1'b1;
    ini0 = 1'b0;
    ini2 = 1'b0;
    repeat (3) @(negedge clk);
    revisar_cero("reset dut0", ocup0, hecho0, pasa0, err0, fv0, pf0, x0, y0);
    revisar_cero("reset dut2", ocup2, hecho2, pasa2, err2, fv2, pf2, x2, y2);
    rst0 = 1'b0;
    rst2 = 1'b0;
    repeat (4) @(negedge clk);
    revisar_cero("tras_reset dut0", ocup0, hecho0, pasa0, err0, fv0, pf0, x0, y0);

    // Good adders, both latencies.
    pulso(2'b11);
    esperar_vacio();

    // Sum bit 0 stuck, then carry stuck.
    modo0 = 1;
    pulso(2'b01);
    esperar_vacio();
    modo0 = 2;
    pulso(2'b01);
    esperar_vacio();

    // Reset in the middle of a sweep at pair 100.
    modo0 = 0;
    pulso(2'b01);
    e = ciclo;
    while (ciclo < e + 100) @(negedge clk);
    rst0 = 1'b1;
    #1;
    revisar_cero("reset_medio dut0", ocup0, hecho0, pasa0, err0, fv0, pf0, x0, y0);
    q0.delete();
    @(negedge clk);
    revisar_cero("reset_medio_sostenido dut0", ocup0, hecho0, pasa0, err0, fv0, pf0, x0, y0);
    rst0 = 1'b0;
    repeat (3) @(negedge clk);
    revisar_cero("reset_medio_liberado dut0", ocup0, hecho0, pasa0, err0, fv0, pf0, x0, y0);
    pulso(2'b01);
    esperar_vacio();

    // Start request while busy at pair 50 must be ignored.
    pulso(2'b01);
    e = ciclo;
    while (ciclo < e + 50) @(negedge clk);
    ini0 = 1'b1;
    @(negedge clk);
    ini0 = 1'b0;
    esperar_vacio();

    // Inicio held high: back-to-back sweeps, restart at the single FIN cycle.
    @(negedge clk);
    ini0 = 1'b1;
    @(negedge clk);
    e = ciclo;
    q0.push_back(modelo(e, 0, modo0, blanco0, mascara0));
    q0.push_back(modelo(e + 258, 0, modo0, blanco0, mascara0));
    while (ciclo < e + 258) @(negedge clk);
    ini0 = 1'b0;
    esperar_vacio();

    // Randomized fault configurations, with stray start requests while busy.
    for (int r = 0; r < 6; r++) begin
      int unsigned retraso;
      modo0 = $urandom_range(0, 3);
      modo2 = $urandom_range(0, 3);
      blanco0 = 8'($urandom);
      blanco2 = 8'($urandom);
      mascara0 = 5'($urandom_range(1, 31));
      mascara2 = 5'($urandom_range(1, 31));
      pulso(2'b11);
      retraso = $urandom_range(1, 240);
      repeat (retraso) @(negedge clk);
      ini0 = 1'b1;
      ini2 = 1'b1;
      @(negedge clk);
      ini0 = 1'b0;
      ini2 = 1'b0;
      esperar_vacio();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", evaluadas, fallos);
    $finish;
  end

endmodule
